// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer and UART framing logic.
// Holds the sequencer state encoding, command length and command field order.
// Default error byte and ALU timeout live here so framing and sequencer agree.
package alu_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_EXEC    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_PUSH_HI = 3'd4,
        ST_PUSH_LO = 3'd5,
        ST_ERR     = 3'd6
    } seq_state_e;

    // Command is opcode, operand A, operand B, in that byte order on the wire
    localparam int CMD_BYTES = 3;

    typedef enum logic [1:0] {
        FIELD_OP = 2'd0,
        FIELD_A  = 2'd1,
        FIELD_B  = 2'd2
    } cmd_field_e;

    localparam int         DEF_TIMEOUT  = 255;
    localparam logic [7:0] DEF_ERR_CODE = 8'hEE;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Purpose: pops 3-byte commands (op, a, b) from RX FIFO, runs the ALU, pushes the result (hi byte first) to TX FIFO.
// Latency: alu_start 6 cycles after the first read with 3 bytes queued; result bytes written 1 and 2 cycles after alu_done.
// Backpressure: stalls in FETCH while rx_empty and in PUSH_*/ERR while tx_full; strobes never fire against a blocked FIFO.
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   rx_empty/rx_rd_en/rx_data - RX FIFO pop interface (data valid the cycle after a read)
//   alu_start/alu_op/alu_a/alu_b - ALU launch pulse and registered command fields
//   alu_done/alu_result    - ALU completion pulse and 2*WIDTH result
//   tx_full/tx_wr_en/tx_data - TX FIFO push interface
//   busy                   - command partially fetched or in flight
//   cmd_err                - pulse coincident with the error-byte write
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int                WIDTH    = 8,
    parameter int                NUM_OPS  = 8,
    parameter int                TIMEOUT  = DEF_TIMEOUT,
    parameter logic [WIDTH-1:0]  ERR_CODE = WIDTH'(DEF_ERR_CODE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_empty,
    output logic                 rx_rd_en,
    input  logic [WIDTH-1:0]     rx_data,
    output logic                 alu_start,
    output logic [WIDTH-1:0]     alu_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic                 alu_done,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic                 tx_full,
    output logic                 tx_wr_en,
    output logic [WIDTH-1:0]     tx_data,
    output logic                 busy,
    output logic                 cmd_err
);

    // Counter reaches TIMEOUT on the same edge the FSM leaves WAIT
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_e           r_state;
    cmd_field_e           r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_result;
    logic                 w_op_ok;

    // Opcode was latched two bytes earlier, so the legality decision is ready at the last capture
    assign w_op_ok = (32'(r_op) < 32'(NUM_OPS));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_idx    <= FIELD_OP;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    // Index is kept while starved so a partial command resumes where it stopped
                    if (!rx_empty) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    case (r_idx)
                        FIELD_OP: r_op <= rx_data;
                        FIELD_A:  r_a  <= rx_data;
                        default:  r_b  <= rx_data;
                    endcase
                    if (r_idx == FIELD_B) begin
                        r_idx   <= FIELD_OP;
                        r_state <= w_op_ok ? ST_EXEC : ST_ERR;
                    end else begin
                        r_idx   <= cmd_field_e'(r_idx + 2'd1);
                        r_state <= ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        r_result <= alu_result;
                        r_state  <= ST_PUSH_HI;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_PUSH_HI: begin
                    if (!tx_full) begin
                        r_state <= ST_PUSH_LO;
                    end
                end
                ST_PUSH_LO: begin
                    if (!tx_full) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_ERR: begin
                    if (!tx_full) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // Strobes decode the state register; reset forces them low so nothing moves in the reset cycle
    always_comb begin
        rx_rd_en  = 1'b0;
        alu_start = 1'b0;
        tx_wr_en  = 1'b0;
        tx_data   = '0;
        cmd_err   = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            busy = !((r_state == ST_FETCH) && (r_idx == FIELD_OP));
            case (r_state)
                ST_FETCH: begin
                    rx_rd_en = !rx_empty;
                end
                ST_EXEC: begin
                    alu_start = 1'b1;
                end
                ST_PUSH_HI: begin
                    tx_data  = r_result[2*WIDTH-1:WIDTH];
                    tx_wr_en = !tx_full;
                end
                ST_PUSH_LO: begin
                    tx_data  = r_result[WIDTH-1:0];
                    tx_wr_en = !tx_full;
                end
                ST_ERR: begin
                    tx_data  = ERR_CODE;
                    tx_wr_en = !tx_full;
                    cmd_err  = !tx_full;
                end
                default: begin
                    tx_data = '0;
                end
            endcase
        end
    end

    assign alu_op = r_op;
    assign alu_a  = r_a;
    assign alu_b  = r_b;

endmodule
